// File: rtl/rc4_key_search_controller.sv
// rc4_key_search_controller
//
// Top-level scheduler for the RC4 brute-force key search. For each candidate
// key it runs the S-memory init engine, the KSA engine and the decryption
// engine in turn, hands the single-port S-memory to whichever engine owns the
// current phase, and snoops the decrypted output to decide whether the
// plaintext looks like lowercase text. It stops on the first good key or when
// the key range is exhausted.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   start                          one-cycle search request (ignored while busy)
//   busy, done, key_found          search status (registered)
//   current_key                    key under test / winning key
//   init_/ksa_/dec_start           one-cycle engine start pulses
//   init_/ksa_/dec_finish          one-cycle engine finish pulses
//   init_/ksa_/dec_s_addr/wdata/wren  per-engine S-memory requests
//   s_mem_addr/data_write/wren     arbitrated S-memory port
//   dec_out_wren, dec_out_data     snoop of the decryptor's output-RAM writes
module rc4_key_search_controller #(
  parameter int                   KEY_WIDTH      = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START      = KEY_WIDTH'(24'h000000),
  parameter logic [KEY_WIDTH-1:0] KEY_END        = KEY_WIDTH'(24'h3FFFFF),
  parameter int                   MESSAGE_LENGTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 key_found,
  output logic [KEY_WIDTH-1:0] current_key,
  output logic                 init_start,
  output logic                 ksa_start,
  output logic                 dec_start,
  input  logic                 init_finish,
  input  logic                 ksa_finish,
  input  logic                 dec_finish,
  input  logic [7:0]           init_s_addr,
  input  logic [7:0]           ksa_s_addr,
  input  logic [7:0]           dec_s_addr,
  input  logic [7:0]           init_s_wdata,
  input  logic [7:0]           ksa_s_wdata,
  input  logic [7:0]           dec_s_wdata,
  input  logic                 init_s_wren,
  input  logic                 ksa_s_wren,
  input  logic                 dec_s_wren,
  output logic [7:0]           s_mem_addr,
  output logic [7:0]           s_mem_data_write,
  output logic                 s_mem_wren,
  input  logic                 dec_out_wren,
  input  logic [7:0]           dec_out_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_GO, S_INIT_WAIT, S_KSA_GO, S_KSA_WAIT, S_DEC_GO,
    S_DEC_WAIT, S_CHECK, S_NEXT_KEY, S_FOUND, S_EXHAUSTED
  } state_t;

  localparam logic [5:0] MSG_LEN = 6'(MESSAGE_LENGTH);

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 bad_q, bad_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 found_q, found_d;

  // Acceptable plaintext: lowercase letters and space.
  function automatic logic is_text(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  // Byte counter saturates so an over-long message can never wrap back to
  // a matching length.
  function automatic logic [5:0] sat_inc(input logic [5:0] c);
    return (c == 6'd63) ? c : c + 6'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      key_q   <= KEY_START;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (start) begin
          key_d   = KEY_START;
          state_d = S_INIT_GO;
        end
      end
      S_INIT_GO:   state_d = S_INIT_WAIT;
      S_INIT_WAIT: if (init_finish) state_d = S_KSA_GO;
      S_KSA_GO:    state_d = S_KSA_WAIT;
      S_KSA_WAIT:  if (ksa_finish) state_d = S_DEC_GO;
      S_DEC_GO: begin
        cnt_d   = '0;
        bad_d   = 1'b0;
        state_d = S_DEC_WAIT;
      end
      S_DEC_WAIT: begin
        // A byte written in the same cycle as dec_finish is still counted.
        if (dec_out_wren) begin
          cnt_d = sat_inc(cnt_q);
          if (!is_text(dec_out_data)) bad_d = 1'b1;
        end
        if (dec_finish) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!bad_q && (cnt_q == MSG_LEN)) state_d = S_FOUND;
        else                              state_d = S_NEXT_KEY;
      end
      S_NEXT_KEY: begin
        if (key_q == KEY_END) begin
          state_d = S_EXHAUSTED;
        end else begin
          key_d   = key_q + KEY_WIDTH'(1);
          state_d = S_INIT_GO;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered images of the next state.
    busy_d  = !((state_d == S_IDLE) || (state_d == S_FOUND) || (state_d == S_EXHAUSTED));
    done_d  = (state_d == S_FOUND) || (state_d == S_EXHAUSTED);
    found_d = (state_d == S_FOUND);
  end

  // S-memory mux decoded straight from the state register: no added latency.
  always_comb begin
    s_mem_addr       = 8'h00;
    s_mem_data_write = 8'h00;
    s_mem_wren       = 1'b0;
    case (state_q)
      S_INIT_GO, S_INIT_WAIT: begin
        s_mem_addr       = init_s_addr;
        s_mem_data_write = init_s_wdata;
        s_mem_wren       = init_s_wren;
      end
      S_KSA_GO, S_KSA_WAIT: begin
        s_mem_addr       = ksa_s_addr;
        s_mem_data_write = ksa_s_wdata;
        s_mem_wren       = ksa_s_wren;
      end
      S_DEC_GO, S_DEC_WAIT: begin
        s_mem_addr       = dec_s_addr;
        s_mem_data_write = dec_s_wdata;
        s_mem_wren       = dec_s_wren;
      end
      default: ;
    endcase
  end

  assign init_start  = (state_q == S_INIT_GO);
  assign ksa_start   = (state_q == S_KSA_GO);
  assign dec_start   = (state_q == S_DEC_GO);
  assign busy        = busy_q;
  assign done        = done_q;
  assign key_found   = found_q;
  assign current_key = key_q;

endmodule

// File: tb/tb_rc4_key_search_controller.sv
module tb_rc4_key_search_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, key_found;
  logic [23:0] current_key;
  logic        init_start, ksa_start, dec_start;
  logic        init_finish = 1'b0, ksa_fin_m = 1'b0, ksa_stray = 1'b0, dec_finish = 1'b0;
  logic [7:0]  init_addr = 8'h11, init_wdata = 8'h22;
  logic [7:0]  ksa_addr  = 8'h33, ksa_wdata  = 8'h44;
  logic [7:0]  dec_addr  = 8'h55, dec_wdata  = 8'h66;
  logic        init_wren = 1'b1, ksa_wren = 1'b0, dec_wren = 1'b1;
  logic [7:0]  s_mem_addr, s_mem_data_write;
  logic        s_mem_wren;
  logic        dec_out_wren = 1'b0;
  logic [7:0]  dec_out_data = 8'h00;

  int total = 0;
  int bad = 0;
  int mode_v = 0;
  int abort_gen = 0;

  typedef struct packed {
    logic        found;
    logic [23:0] key;
    logic [31:0] attempts;
  } exp_t;
  exp_t sb[$];

  rc4_key_search_controller #(
    .KEY_WIDTH(24), .KEY_START(24'h000000), .KEY_END(24'h000002), .MESSAGE_LENGTH(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .busy(busy), .done(done), .key_found(key_found), .current_key(current_key),
    .init_start(init_start), .ksa_start(ksa_start), .dec_start(dec_start),
    .init_finish(init_finish), .ksa_finish(ksa_fin_m | ksa_stray), .dec_finish(dec_finish),
    .init_s_addr(init_addr), .ksa_s_addr(ksa_addr), .dec_s_addr(dec_addr),
    .init_s_wdata(init_wdata), .ksa_s_wdata(ksa_wdata), .dec_s_wdata(dec_wdata),
    .init_s_wren(init_wren), .ksa_s_wren(ksa_wren), .dec_s_wren(dec_wren),
    .s_mem_addr(s_mem_addr), .s_mem_data_write(s_mem_data_write), .s_mem_wren(s_mem_wren),
    .dec_out_wren(dec_out_wren), .dec_out_data(dec_out_data)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] valid_byte(input int i);
    case (i % 4)
      0:       return 8'h20;
      1:       return 8'h61;
      2:       return 8'h7A;
      default: return 8'h6D;
    endcase
  endfunction

  function automatic logic [7:0] dec_byte(input int m, input int k, input int i);
    logic [7:0] bad_tbl [3];
    bad_tbl[0] = 8'h7B; bad_tbl[1] = 8'h60; bad_tbl[2] = 8'h21;
    case (m)
      1:       return (k < 2 && i == 7) ? 8'h41 : valid_byte(i);
      2:       return (i == k * 5) ? bad_tbl[k % 3] : 8'h61;
      3:       return valid_byte(i);
      default: return 8'h61;
    endcase
  endfunction

  // Init engine model: finishes 5 cycles after its start.
  initial forever begin
    @(negedge clk);
    if (init_start && reset_n) begin
      repeat (4) @(negedge clk);
      init_finish = 1'b1;
      @(negedge clk);
      init_finish = 1'b0;
      check("handoff_init_to_ksa", ksa_start, 1);
    end
  end

  // KSA engine model; abandons its run if reset hits while it is working.
  initial forever begin
    int g;
    @(negedge clk);
    if (ksa_start && reset_n) begin
      g = abort_gen;
      repeat (4) @(negedge clk);
      if (g == abort_gen) begin
        ksa_fin_m = 1'b1;
        @(negedge clk);
        ksa_fin_m = 1'b0;
        check("handoff_ksa_to_dec", dec_start, 1);
      end
    end
  end

  // Decrypt engine model: writes bytes (with idle gaps carrying junk data),
  // raising dec_finish together with the last byte.
  initial forever begin
    int k, nb;
    @(negedge clk);
    if (dec_start && reset_n) begin
      k  = int'(current_key);
      nb = (mode_v == 3 && k == 0) ? 31 : (mode_v == 3 && k == 1) ? 96 : 32;
      for (int i = 0; i < nb; i++) begin
        if (i % 3 == 0) begin
          dec_out_wren = 1'b0;
          dec_out_data = 8'h00;
          @(negedge clk);
        end
        dec_out_wren = 1'b1;
        dec_out_data = dec_byte(mode_v, k, i);
        dec_finish   = (i == nb - 1);
        ksa_stray    = (mode_v == 3 && i == 5);
        @(negedge clk);
      end
      dec_out_wren = 1'b0;
      dec_finish   = 1'b0;
      ksa_stray    = 1'b0;
      check("check_cycle_busy", busy, 1);
      check("check_cycle_wren", s_mem_wren, 0);
    end
  end

  // Monitor: arbitration, start ordering, and scoreboard on done rising.
  initial begin
    int owner, last_st, n_init, n_ksa, n_dec;
    logic done_prev, pi, pk, pd;
    logic [7:0] ea, ed;
    logic ew;
    exp_t e;
    owner = 0; last_st = 0; n_init = 0; n_ksa = 0; n_dec = 0;
    done_prev = 1'b0; pi = 1'b0; pk = 1'b0; pd = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        owner = 0; last_st = 0; n_init = 0; n_ksa = 0; n_dec = 0;
        done_prev = 1'b0; pi = 1'b0; pk = 1'b0; pd = 1'b0;
      end else begin
        if (dec_finish && owner == 3) owner = 0;
        if (init_start) begin
          check("init_order", (last_st == 0 || last_st == 3), 1);
          check("init_one_cycle", pi, 0);
          n_init++; last_st = 1; owner = 1;
        end
        if (ksa_start) begin
          check("ksa_order", (last_st == 1), 1);
          check("ksa_one_cycle", pk, 0);
          n_ksa++; last_st = 2; owner = 2;
        end
        if (dec_start) begin
          check("dec_order", (last_st == 2), 1);
          check("dec_one_cycle", pd, 0);
          n_dec++; last_st = 3; owner = 3;
        end
        case (owner)
          1:       begin ea = init_addr; ed = init_wdata; ew = init_wren; end
          2:       begin ea = ksa_addr;  ed = ksa_wdata;  ew = ksa_wren;  end
          3:       begin ea = dec_addr;  ed = dec_wdata;  ew = dec_wren;  end
          default: begin ea = 8'h00;     ed = 8'h00;      ew = 1'b0;      end
        endcase
        check("smem_addr", s_mem_addr, ea);
        check("smem_wdata", s_mem_data_write, ed);
        check("smem_wren", s_mem_wren, ew);
        if (done && !done_prev) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("sb_key_found", key_found, e.found);
            check("sb_current_key", current_key, e.key);
            check("sb_attempts_init", n_init, e.attempts);
            check("sb_attempts_dec", n_dec, e.attempts);
            check("sb_attempts_ksa", n_ksa, e.attempts);
            check("sb_busy_low", busy, 0);
          end
          n_init = 0; n_ksa = 0; n_dec = 0; last_st = 0; owner = 0;
        end
        done_prev = done; pi = init_start; pk = ksa_start; pd = dec_start;
      end
    end
  end

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic run_search(input int m, input logic f, input logic [23:0] k,
                            input int att, input bit poke);
    exp_t e;
    mode_v     = m;
    e.found    = f;
    e.key      = k;
    e.attempts = att;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_latency_init", init_start, 1);
    check("start_busy", busy, 1);
    check("start_clears_done", done, 0);
    check("start_clears_found", key_found, 0);
    if (poke) begin
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(3000);
    repeat (3) @(negedge clk);
    check("done_held", done, 1);
    check("key_held", current_key, k);
    check("found_held", key_found, f);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", key_found, 0);
    check("rst_key", current_key, 0);
    check("rst_smem_wren", s_mem_wren, 0);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (init_start || ksa_start || dec_start || busy || done) n++;
    end
    check("idle_quiet", n, 0);
    check("idle_key", current_key, 0);

    run_search(0, 1'b1, 24'd0, 1, 1'b0);  // all 'a': first key wins
    run_search(1, 1'b1, 24'd2, 3, 1'b1);  // 'A' in byte 7 for keys 0,1; start poked mid-run
    run_search(2, 1'b0, 24'd2, 3, 1'b0);  // one bad byte per key: exhausted at KEY_END
    run_search(3, 1'b1, 24'd2, 3, 1'b0);  // 31 bytes, then 96 bytes, then 32 good

    // Reset in the middle of KSA_WAIT.
    mode_v = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!ksa_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_ksa", ksa_start, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    abort_gen++;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_key", current_key, 0);
    check("abort_ksa_start", ksa_start, 0);
    check("abort_smem_addr", s_mem_addr, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_abort_idle", busy, 0);
    run_search(0, 1'b1, 24'd0, 1, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
